// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiplier slice:
// FSM state encoding, IEEE-754 field constants, status flag bundle.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int          EXP_BIAS = 127;
    localparam int          MANT_W   = 24;
    localparam int          EXP_W    = 10;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef struct packed {
        logic of;
        logic uf;
        logic nanf;
        logic inff;
        logic dnf;
        logic zf;
    } fp_flags_t;

    function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_mul_core_if.sv
// Start/operand/result bundle between the FP multiplier wrapper (master)
// and fp_mul_core (slave).
interface fp_mul_core_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        done;
    logic [31:0] p;
    logic        of;
    logic        uf;
    logic        nanf;
    logic        inff;
    logic        dnf;
    logic        zf;

    modport master (output start, op_a, op_b,
                    input  done, p, of, uf, nanf, inff, dnf, zf);
    modport slave  (input  start, op_a, op_b,
                    output done, p, of, uf, nanf, inff, dnf, zf);
endinterface

// File: rtl/fp_unpack.sv
// Splits a single-precision word into fields and classifies it.
// Denormals are flushed: their mantissa comes out as zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [7:0]        exp,
    output logic [MANT_W-1:0] mant,
    output logic              is_zero,
    output logic              is_dn,
    output logic              is_inf,
    output logic              is_nan
);

    logic frac_nz_s;

    // Field extraction and operand classification
    always_comb begin
        sign      = word[31];
        exp       = word[30:23];
        frac_nz_s = (word[22:0] != 23'd0);
        is_zero   = (exp == 8'd0) && !frac_nz_s;
        is_dn     = (exp == 8'd0) && frac_nz_s;
        is_inf    = (exp == 8'hFF) && !frac_nz_s;
        is_nan    = (exp == 8'hFF) && frac_nz_s;
        if (exp == 8'd0) begin
            mant = 24'd0;
        end else begin
            mant = {1'b1, word[22:0]};
        end
    end

endmodule

// File: rtl/fp_mul_core.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add mantissa
// product (R bits per cycle), normalize, round-to-nearest-even, fixed latency.
module fp_mul_core
    import fp_pkg::*;
#(
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_core_if.slave bus
);

    localparam logic [4:0] MULT_CYC = 5'(MANT_W / R);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [47:0]        mcand_q, mcand_d, acc_q, acc_d;
    logic [23:0]        mplier_q, mplier_d;
    logic [22:0]        mant_q, mant_d;
    logic               guard_q, guard_d, sticky_q, sticky_d;
    logic               nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, dn_q, dn_d;
    logic [31:0]        p_q, p_d;
    fp_flags_t          flags_q, flags_d;
    logic               done_q, done_d;

    logic               ua_sign_s, ub_sign_s;
    logic [7:0]         ua_exp_s, ub_exp_s;
    logic [23:0]        ua_mant_s, ub_mant_s;
    logic               ua_zero_s, ua_dn_s, ua_inf_s, ua_nan_s;
    logic               ub_zero_s, ub_dn_s, ub_inf_s, ub_nan_s;
    logic [47:0]        pp_s;
    logic [23:0]        rnd_s;
    logic signed [EXP_W-1:0] exp_r_s;

    fp_unpack u_unpack_a (
        .word(a_q), .sign(ua_sign_s), .exp(ua_exp_s), .mant(ua_mant_s),
        .is_zero(ua_zero_s), .is_dn(ua_dn_s), .is_inf(ua_inf_s), .is_nan(ua_nan_s)
    );

    fp_unpack u_unpack_b (
        .word(b_q), .sign(ub_sign_s), .exp(ub_exp_s), .mant(ub_mant_s),
        .is_zero(ub_zero_s), .is_dn(ub_dn_s), .is_inf(ub_inf_s), .is_nan(ub_nan_s)
    );

    // Next-state and datapath computation for every register
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        dn_d     = dn_q;
        p_d      = p_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        pp_s     = 48'd0;
        rnd_s    = 24'd0;
        exp_r_s  = exp_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    state_d = UNPACK;
                end else begin
                    state_d = IDLE;
                end
            end
            UNPACK: begin
                sign_d   = ua_sign_s ^ ub_sign_s;
                exp_d    = {2'b00, ua_exp_s} + {2'b00, ub_exp_s} - 10'(EXP_BIAS);
                mcand_d  = {24'd0, ua_mant_s};
                mplier_d = ub_mant_s;
                acc_d    = 48'd0;
                cnt_d    = MULT_CYC;
                // A flushed denormal behaves as zero for inf x zero
                nan_d    = ua_nan_s | ub_nan_s
                         | (ua_inf_s & (ub_zero_s | ub_dn_s))
                         | (ub_inf_s & (ua_zero_s | ua_dn_s));
                inf_d    = ua_inf_s | ub_inf_s;
                zero_d   = ua_zero_s | ua_dn_s | ub_zero_s | ub_dn_s;
                dn_d     = ua_dn_s | ub_dn_s;
                state_d  = MULT;
            end
            MULT: begin
                for (int i = 0; i < R; i++) begin
                    if (mplier_q[i]) begin
                        pp_s = pp_s + (mcand_q << i);
                    end else begin
                        pp_s = pp_s;
                    end
                end
                acc_d    = acc_q + pp_s;
                mcand_d  = mcand_q << R;
                mplier_d = mplier_q >> R;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = NORM;
                end else begin
                    state_d = MULT;
                end
            end
            NORM: begin
                if (acc_q[47]) begin
                    exp_d    = exp_q + 10'sd1;
                    mant_d   = acc_q[46:24];
                    guard_d  = acc_q[23];
                    sticky_d = |acc_q[22:0];
                end else begin
                    mant_d   = acc_q[45:23];
                    guard_d  = acc_q[22];
                    sticky_d = |acc_q[21:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                // Carry-out leaves rnd_s[22:0] at zero, which is the cleared mantissa
                rnd_s   = {1'b0, mant_q} + {23'd0, guard_q & (sticky_q | mant_q[0])};
                exp_r_s = rnd_s[23] ? exp_q + 10'sd1 : exp_q;
                flags_d = '0;
                flags_d.dnf = dn_q;
                if (nan_q) begin
                    p_d = QNAN;
                    flags_d.nanf = 1'b1;
                end else if (inf_q) begin
                    p_d = fp_pack(sign_q, 8'hFF, 23'd0);
                    flags_d.inff = 1'b1;
                end else if (zero_q) begin
                    p_d = fp_pack(sign_q, 8'h00, 23'd0);
                    flags_d.zf = 1'b1;
                end else if (exp_r_s >= 10'sd255) begin
                    p_d = fp_pack(sign_q, 8'hFF, 23'd0);
                    flags_d.of   = 1'b1;
                    flags_d.inff = 1'b1;
                end else if (exp_r_s <= 10'sd0) begin
                    p_d = fp_pack(sign_q, 8'h00, 23'd0);
                    flags_d.uf = 1'b1;
                    flags_d.zf = 1'b1;
                end else begin
                    p_d = fp_pack(sign_q, exp_r_s[7:0], rnd_s[22:0]);
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
            mant_q   <= 23'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dn_q     <= 1'b0;
            p_q      <= 32'd0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            dn_q     <= dn_d;
            p_q      <= p_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.done = done_q;
    assign bus.p    = p_q;
    assign bus.of   = flags_q.of;
    assign bus.uf   = flags_q.uf;
    assign bus.nanf = flags_q.nanf;
    assign bus.inff = flags_q.inff;
    assign bus.dnf  = flags_q.dnf;
    assign bus.zf   = flags_q.zf;

endmodule

// File: tb/tb_fp_mul_core.sv
// Directed bench for fp_mul_core: arithmetic/special vectors at R=1,
// protocol checks (busy start, mid-op reset), and latency at R=4.
module tb_fp_mul_core;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    fp_mul_core_if bus1 ();
    fp_mul_core_if bus4 ();

    fp_mul_core #(.R(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fp_mul_core #(.R(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag order: {of, uf, nanf, inff, dnf, zf}
    logic [31:0] vec_a   [10] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                                  32'h00800000, 32'h7F800000, 32'h00000001, 32'hFF800000,
                                  32'h3F800001, 32'h3F800003};
    logic [31:0] vec_b   [10] = '{32'h40400000, 32'hBFC00000, 32'h3F800001, 32'h7F000000,
                                  32'h00800000, 32'h00000000, 32'h3F800000, 32'h40000000,
                                  32'h3FC00000, 32'h3FC00000};
    logic [31:0] vec_p   [10] = '{32'h40C00000, 32'hC0100000, 32'h3F800002, 32'h7F800000,
                                  32'h00000000, 32'h7FC00000, 32'h00000000, 32'hFF800000,
                                  32'h3FC00002, 32'h3FC00004};
    logic [5:0]  vec_f   [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b100100,
                                  6'b010001, 6'b001000, 6'b000011, 6'b000100,
                                  6'b000000, 6'b000000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags1();
        return {bus1.of, bus1.uf, bus1.nanf, bus1.inff, bus1.dnf, bus1.zf};
    endfunction

    function automatic logic [5:0] flags4();
        return {bus4.of, bus4.uf, bus4.nanf, bus4.inff, bus4.dnf, bus4.zf};
    endfunction

    // Launch one operation and wait (bounded) for its done pulse; lat=0 on timeout
    task automatic run_op(input bit sel4, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] pr, output logic [5:0] fl);
        @(negedge clk);
        if (sel4) begin
            bus4.op_a = a; bus4.op_b = b; bus4.start = 1'b1;
        end else begin
            bus1.op_a = a; bus1.op_b = b; bus1.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus1.start = 1'b0; bus4.start = 1'b0;
        bus1.op_a = 32'hDEADBEEF; bus1.op_b = 32'h12345678;
        bus4.op_a = 32'hDEADBEEF; bus4.op_b = 32'h12345678;
        lat = 0; pr = 32'd0; fl = 6'd0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (sel4 ? bus4.done : bus1.done) begin
                lat = n;
                pr  = sel4 ? bus4.p : bus1.p;
                fl  = sel4 ? flags4() : flags1();
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          ndone;
        int          first;
        logic [31:0] pr;
        logic [5:0]  fl;

        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.op_a = 32'd0; bus1.op_b = 32'd0;
        bus4.start = 1'b0; bus4.op_a = 32'd0; bus4.op_b = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_p", bus1.p, 32'd0);
        check("rst_flags", {26'd0, flags1()}, 32'd0);
        check("rst_done", {31'd0, bus1.done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, vec_a[i], vec_b[i], lat, pr, fl);
            check($sformatf("v%0d_p", i), pr, vec_p[i]);
            check($sformatf("v%0d_flags", i), {26'd0, fl}, {26'd0, vec_f[i]});
            check($sformatf("v%0d_lat", i), lat, 28);
        end

        // Start pulsed during MULT must be ignored
        @(negedge clk);
        bus1.op_a = 32'h40000000; bus1.op_b = 32'h40400000; bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        ndone = 0; first = 0; pr = 32'd0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus1.start = (n == 10);
            if (bus1.done) begin
                ndone++;
                if (first == 0) begin
                    first = n;
                    pr = bus1.p;
                end
            end
        end
        bus1.start = 1'b0;
        check("busy_ndone", ndone, 1);
        check("busy_lat", first, 28);
        check("busy_p", pr, 32'h40C00000);

        // Reset in cycle 15 aborts the operation
        @(negedge clk);
        bus1.op_a = 32'h3FC00000; bus1.op_b = 32'hBFC00000; bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            rst = (n == 15);
            if (bus1.done) ndone++;
        end
        rst = 1'b0;
        check("abort_ndone", ndone, 0);
        check("abort_p", bus1.p, 32'd0);
        check("abort_flags", {26'd0, flags1()}, 32'd0);

        run_op(1'b0, 32'h3FC00000, 32'hBFC00000, lat, pr, fl);
        check("fresh_p", pr, 32'hC0100000);
        check("fresh_lat", lat, 28);

        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, vec_a[i], vec_b[i], lat, pr, fl);
            check($sformatf("r4_v%0d_p", i), pr, vec_p[i]);
            check($sformatf("r4_v%0d_flags", i), {26'd0, fl}, {26'd0, vec_f[i]});
            check($sformatf("r4_v%0d_lat", i), lat, 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
